// File: rtl/tdc_meas_sequencer_if.sv
// SDK-side register/readout bus of the TDC measurement sequencer.
// The master is the SDK register block and the slave is the sequencer.
interface tdc_meas_sequencer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          cfg_go;
    logic [15:0]   cfg_count;
    logic          cfg_abort;
    logic          fifo_rd_en;
    logic [63:0]   fifo_rd_data;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic [15:0]   ok_cnt;
    logic [15:0]   to_cnt;
    logic          timeout_err;
    logic          overflow_err;

    modport master (
        output cfg_go, cfg_count, cfg_abort, fifo_rd_en,
        input  fifo_rd_data, fifo_empty, fifo_level, busy,
               ok_cnt, to_cnt, timeout_err, overflow_err
    );

    modport slave (
        input  cfg_go, cfg_count, cfg_abort, fifo_rd_en,
        output fifo_rd_data, fifo_empty, fifo_level, busy,
               ok_cnt, to_cnt, timeout_err, overflow_err
    );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// TDC time-of-flight measurement sequencer.
// Gates the raw start/stop events into fixed-width pulses for the datapath,
// waits for its result with a timeout, and buffers results in a FWFT FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no run active; cfg_go starts a run
// ARM       | waiting for a start edge (no timeout)
// WAIT_STOP | start pulse issued, waiting for a stop edge (timed)
// WAIT_DONE | stop pulse issued, waiting for meas_done (timed)
// STORE     | one cycle: push captured result into the FIFO or drop it
// GAP       | holdoff so the datapath can settle before the next measurement
module tdc_meas_sequencer #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int          PULSE_LEN   = 4,
    parameter int          HOLDOFF     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    tdc_meas_sequencer_if.slave       bus,
    input  logic                      start_in,
    input  logic                      stop_in,
    output logic                      start_out,
    output logic                      stop_out,
    input  logic                      meas_done,
    input  logic [63:0]               meas_time
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(PULSE_LEN) + 1;
    localparam int HW = $clog2(HOLDOFF) + 1;
    localparam logic [31:0]   TMO_LOAD   = 32'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_STOP, WAIT_DONE, STORE, GAP
    } state_t;

    state_t        state;
    logic [2:0]    start_sync;
    logic [2:0]    stop_sync;
    logic          start_rise;
    logic          stop_rise;
    logic [15:0]   count_lat;
    logic [15:0]   ok_cnt;
    logic [15:0]   to_cnt;
    logic [15:0]   done_sum;
    logic          timeout_err;
    logic          overflow_err;
    logic [31:0]   tmo_cnt;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] start_pcnt;
    logic [PW-1:0] stop_pcnt;
    logic [63:0]   meas_q;

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          fifo_full;
    logic          fifo_wr;
    logic          fifo_rd;

    // Bits [1:0] are the two-flop synchroniser, bit [2] is the edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_sync <= '0;
            stop_sync  <= '0;
        end else begin
            start_sync <= {start_sync[1:0], start_in};
            stop_sync  <= {stop_sync[1:0], stop_in};
        end
    end

    assign start_rise = start_sync[1] & ~start_sync[2];
    assign stop_rise  = stop_sync[1] & ~stop_sync[2];
    assign done_sum   = ok_cnt + to_cnt;

    // A full FIFO still accepts the write when the SDK pops in the same cycle.
    assign fifo_full = (level == LW'(FIFO_DEPTH));
    assign fifo_rd   = bus.fifo_rd_en && (level != '0);
    assign fifo_wr   = (state == STORE) && !bus.cfg_abort && (!fifo_full || bus.fifo_rd_en);

    // Sequencer FSM with pulse timers, timeout, holdoff and run counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count_lat    <= '0;
            ok_cnt       <= '0;
            to_cnt       <= '0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            tmo_cnt      <= '0;
            hold_cnt     <= '0;
            start_out    <= 1'b0;
            stop_out     <= 1'b0;
            start_pcnt   <= '0;
            stop_pcnt    <= '0;
            meas_q       <= '0;
        end else begin
            if (start_out) begin
                if (start_pcnt == '0) start_out <= 1'b0;
                else                  start_pcnt <= start_pcnt - 1'b1;
            end
            if (stop_out) begin
                if (stop_pcnt == '0) stop_out <= 1'b0;
                else                 stop_pcnt <= stop_pcnt - 1'b1;
            end

            if (bus.cfg_abort && state != IDLE) begin
                state     <= IDLE;
                start_out <= 1'b0;
                stop_out  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.cfg_go) begin
                            count_lat    <= bus.cfg_count;
                            ok_cnt       <= '0;
                            to_cnt       <= '0;
                            timeout_err  <= 1'b0;
                            overflow_err <= 1'b0;
                            state        <= ARM;
                        end
                    end
                    ARM: begin
                        if (start_rise) begin
                            start_out  <= 1'b1;
                            start_pcnt <= PULSE_LOAD;
                            tmo_cnt    <= TMO_LOAD;
                            state      <= WAIT_STOP;
                        end
                    end
                    WAIT_STOP: begin
                        if (stop_rise) begin
                            stop_out  <= 1'b1;
                            stop_pcnt <= PULSE_LOAD;
                            tmo_cnt   <= TMO_LOAD;
                            state     <= WAIT_DONE;
                        end else if (tmo_cnt == '0) begin
                            to_cnt      <= to_cnt + 16'd1;
                            timeout_err <= 1'b1;
                            hold_cnt    <= HOLD_LOAD;
                            state       <= GAP;
                        end else begin
                            tmo_cnt <= tmo_cnt - 32'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (meas_done) begin
                            meas_q <= meas_time;
                            state  <= STORE;
                        end else if (tmo_cnt == '0) begin
                            to_cnt      <= to_cnt + 16'd1;
                            timeout_err <= 1'b1;
                            hold_cnt    <= HOLD_LOAD;
                            state       <= GAP;
                        end else begin
                            tmo_cnt <= tmo_cnt - 32'd1;
                        end
                    end
                    STORE: begin
                        ok_cnt <= ok_cnt + 16'd1;
                        if (!fifo_wr) overflow_err <= 1'b1;
                        hold_cnt <= HOLD_LOAD;
                        state    <= GAP;
                    end
                    GAP: begin
                        if (hold_cnt == '0) begin
                            if (count_lat != '0 && done_sum == count_lat) state <= IDLE;
                            else                                          state <= ARM;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Result FIFO storage, pointers and occupancy; head is presented combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= meas_q;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            if (fifo_wr && !fifo_rd)      level <= level + 1'b1;
            else if (!fifo_wr && fifo_rd) level <= level - 1'b1;
        end
    end

    assign bus.fifo_rd_data = mem[rd_ptr];
    assign bus.fifo_empty   = (level == '0);
    assign bus.fifo_level   = level;
    assign bus.busy         = (state != IDLE);
    assign bus.ok_cnt       = ok_cnt;
    assign bus.to_cnt       = to_cnt;
    assign bus.timeout_err  = timeout_err;
    assign bus.overflow_err = overflow_err;
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Bench for the TDC measurement sequencer: directed runs with a result
// scoreboard checked by a FIFO-pop monitor and a pulse-width monitor.
module tb_tdc_meas_sequencer;
    logic        clk;
    logic        reset_n;
    logic        start_in;
    logic        stop_in;
    logic        start_out;
    logic        stop_out;
    logic        meas_done;
    logic [63:0] meas_time;

    tdc_meas_sequencer_if #(.FIFO_DEPTH(8)) bus ();

    tdc_meas_sequencer #(
        .FIFO_DEPTH (8),
        .TIMEOUT_CYC(200),
        .PULSE_LEN  (4),
        .HOLDOFF    (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .start_in (start_in),
        .stop_in  (stop_in),
        .start_out(start_out),
        .stop_out (stop_out),
        .meas_done(meas_done),
        .meas_time(meas_time)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int          start_w = 0;
    int          stop_w = 0;
    int          start_pulses = 0;
    int          stop_pulses = 0;
    int          exp_stop_w = 4;
    int          base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every FIFO pop is compared with the oldest expected result.
    always @(negedge clk) begin
        if (reset_n && bus.fifo_rd_en && !bus.fifo_empty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_pop: got 0x%0h, expected no data", bus.fifo_rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.fifo_rd_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL fifo_pop: got 0x%0h, expected 0x%0h", bus.fifo_rd_data, mon_exp);
                end
            end
        end
    end

    // Pulse monitor: every completed start/stop pulse is checked for width.
    always @(negedge clk) begin
        if (!reset_n) begin
            start_w = 0;
            stop_w  = 0;
        end else begin
            if (start_out) start_w++;
            else if (start_w != 0) begin
                start_pulses++;
                check("start_out_width", 64'(start_w), 64'd4);
                start_w = 0;
            end
            if (stop_out) stop_w++;
            else if (stop_w != 0) begin
                stop_pulses++;
                check("stop_out_width", 64'(stop_w), 64'(exp_stop_w));
                stop_w = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] count);
        bus.cfg_count = count;
        bus.cfg_go    = 1'b1;
        tick(1);
        bus.cfg_go    = 1'b0;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        tick(5);
        start_in = 1'b0;
        tick(2);
    endtask

    task automatic do_stop();
        stop_in = 1'b1;
        tick(5);
        stop_in = 1'b0;
        tick(2);
    endtask

    task automatic done_pulse(input logic [63:0] val);
        meas_time = val;
        meas_done = 1'b1;
        tick(1);
        meas_done = 1'b0;
    endtask

    task automatic pop(input int n);
        bus.fifo_rd_en = 1'b1;
        tick(n);
        bus.fifo_rd_en = 1'b0;
    endtask

    // One complete measurement; optionally pops during the STORE cycle.
    task automatic measure(input logic [63:0] val, input bit stored, input bit rd_in_store);
        do_start();
        tick(20);
        do_stop();
        tick(10);
        if (stored) exp_q.push_back(val);
        done_pulse(val);
        if (rd_in_store) begin
            bus.fifo_rd_en = 1'b1;
            tick(1);
            bus.fifo_rd_en = 1'b0;
            tick(19);
        end else begin
            tick(20);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_in = 1'b0;
        stop_in = 1'b0;
        meas_done = 1'b0;
        meas_time = '0;
        bus.cfg_go = 1'b0;
        bus.cfg_count = '0;
        bus.cfg_abort = 1'b0;
        bus.fifo_rd_en = 1'b0;
        tick(3);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_fifo_empty", 64'(bus.fifo_empty), 1);
        check("rst_fifo_level", 64'(bus.fifo_level), 0);
        check("rst_fifo_rd_data", bus.fifo_rd_data, 0);
        check("rst_start_out", 64'(start_out), 0);
        check("rst_stop_out", 64'(stop_out), 0);
        check("rst_ok_cnt", 64'(bus.ok_cnt), 0);
        check("rst_to_cnt", 64'(bus.to_cnt), 0);
        check("rst_flags", 64'({bus.timeout_err, bus.overflow_err}), 0);
        reset_n = 1'b1;
        tick(2);

        // Single measurement
        go(1);
        check("single_busy", 64'(bus.busy), 1);
        do_start();
        tick(93);
        do_stop();
        tick(43);
        exp_q.push_back(64'h1234);
        done_pulse(64'h1234);
        tick(16);
        check("single_busy_in_gap", 64'(bus.busy), 1);
        tick(1);
        check("single_busy_after_gap", 64'(bus.busy), 0);
        check("single_level", 64'(bus.fifo_level), 1);
        check("single_ok_cnt", 64'(bus.ok_cnt), 1);
        check("single_to_cnt", 64'(bus.to_cnt), 0);
        check("single_pulses", 64'({start_pulses[7:0], stop_pulses[7:0]}), 64'h0101);
        check("single_head", bus.fifo_rd_data, 64'h1234);
        pop(1);
        check("single_empty_after_pop", 64'(bus.fifo_empty), 1);

        // Three-measurement run, then a stray start edge in IDLE
        base = start_pulses;
        go(3);
        measure(10, 1, 0);
        measure(20, 1, 0);
        measure(30, 1, 0);
        check("run3_busy", 64'(bus.busy), 0);
        check("run3_ok_cnt", 64'(bus.ok_cnt), 3);
        check("run3_to_cnt", 64'(bus.to_cnt), 0);
        check("run3_level", 64'(bus.fifo_level), 3);
        check("run3_start_pulses", 64'(start_pulses - base), 3);
        do_start();
        tick(10);
        check("run3_idle_start_ignored", 64'(start_pulses - base), 3);
        pop(3);

        // Timeout in WAIT_STOP, second measurement completes
        go(2);
        do_start();
        tick(195);
        check("tmo_not_yet", 64'({bus.timeout_err, bus.to_cnt}), 0);
        tick(1);
        check("tmo_err", 64'(bus.timeout_err), 1);
        check("tmo_to_cnt", 64'(bus.to_cnt), 1);
        check("tmo_level_empty", 64'(bus.fifo_level), 0);
        tick(20);
        measure(64'h55, 1, 0);
        check("tmo_busy", 64'(bus.busy), 0);
        check("tmo_ok_cnt", 64'(bus.ok_cnt), 1);
        check("tmo_to_cnt_final", 64'(bus.to_cnt), 1);
        check("tmo_level", 64'(bus.fifo_level), 1);
        pop(1);

        // Overflow without reads
        go(10);
        for (int v = 1; v <= 10; v++) begin
            measure(64'(v), v <= 8, 0);
            if (v == 8) check("ovf_none_at_8", 64'(bus.overflow_err), 0);
        end
        check("ovf_busy", 64'(bus.busy), 0);
        check("ovf_err", 64'(bus.overflow_err), 1);
        check("ovf_ok_cnt", 64'(bus.ok_cnt), 10);
        check("ovf_level", 64'(bus.fifo_level), 8);
        pop(8);
        check("ovf_drained", 64'(bus.fifo_empty), 1);

        // Overflow with a pop in the 9th STORE cycle
        go(10);
        check("ovf2_flags_cleared", 64'(bus.overflow_err), 0);
        for (int v = 1; v <= 8; v++) measure(64'(v), 1, 0);
        measure(9, 1, 1);
        check("ovf2_level_after_9", 64'(bus.fifo_level), 8);
        check("ovf2_no_err_after_9", 64'(bus.overflow_err), 0);
        measure(10, 0, 0);
        check("ovf2_err", 64'(bus.overflow_err), 1);
        check("ovf2_ok_cnt", 64'(bus.ok_cnt), 10);
        check("ovf2_level", 64'(bus.fifo_level), 8);
        pop(8);

        // Abort in WAIT_DONE together with meas_done
        go(2);
        measure(64'h77, 1, 0);
        do_start();
        tick(20);
        stop_in = 1'b1;
        tick(3);
        check("abort_stop_out_high", 64'(stop_out), 1);
        exp_stop_w = 1;
        meas_time = 64'hdead;
        meas_done = 1'b1;
        bus.cfg_abort = 1'b1;
        tick(1);
        meas_done = 1'b0;
        bus.cfg_abort = 1'b0;
        check("abort_stop_out_low", 64'(stop_out), 0);
        check("abort_busy", 64'(bus.busy), 0);
        stop_in = 1'b0;
        tick(5);
        exp_stop_w = 4;
        check("abort_level", 64'(bus.fifo_level), 1);
        check("abort_ok_cnt", 64'(bus.ok_cnt), 1);
        check("abort_head", bus.fifo_rd_data, 64'h77);
        pop(1);

        // Continuous run with a mid-run cfg_go and a stray meas_done
        go(0);
        for (int i = 0; i < 3; i++) measure(64'h101 + 64'(i), 1, 0);
        bus.cfg_count = 16'd1;
        bus.cfg_go = 1'b1;
        tick(1);
        bus.cfg_go = 1'b0;
        meas_time = 64'hbad;
        meas_done = 1'b1;
        tick(1);
        meas_done = 1'b0;
        tick(2);
        check("cont_stray_done_level", 64'(bus.fifo_level), 3);
        check("cont_go_ignored_ok", 64'(bus.ok_cnt), 3);
        measure(64'h104, 1, 0);
        measure(64'h105, 1, 0);
        check("cont_ok_cnt", 64'(bus.ok_cnt), 5);
        check("cont_still_busy", 64'(bus.busy), 1);
        bus.cfg_abort = 1'b1;
        tick(1);
        bus.cfg_abort = 1'b0;
        check("cont_abort_busy", 64'(bus.busy), 0);
        check("cont_abort_ok_kept", 64'(bus.ok_cnt), 5);
        check("cont_level", 64'(bus.fifo_level), 5);
        pop(5);

        // Asynchronous reset mid-run
        go(3);
        measure(64'h99, 1, 0);
        do_start();
        tick(20);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_busy", 64'(bus.busy), 0);
        check("arst_level", 64'(bus.fifo_level), 0);
        check("arst_empty", 64'(bus.fifo_empty), 1);
        check("arst_ok_cnt", 64'(bus.ok_cnt), 0);
        check("arst_rd_data", bus.fifo_rd_data, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_meas_sequencer.md
Name: tdc_meas_sequencer

Overview:
- Sequences single or repeated TDC time-of-flight measurements for the start/stop measurement datapath.
- Gates the raw start/stop event inputs into clean start/stop levels for the datapath.
- Waits for the datapath's done strobe, with a timeout, and buffers each 64-bit result in a FWFT FIFO for SDK readout.
- Sits between the SDK register interface and the measurement datapath; also keeps success and timeout counters.

Parameters:
- FIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2).
- TIMEOUT_CYC, 1000000, clk cycles allowed in WAIT_STOP or WAIT_DONE before abandoning the measurement.
- PULSE_LEN, 4, clk cycles start_out/stop_out are held high.
- HOLDOFF, 16, GAP-state clk cycles between measurements so the datapath can return to idle.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_go  in  1  one-cycle pulse: begin a run.
- cfg_count  in  16  measurements per run; 0 = continuous.
- cfg_abort  in  1  one-cycle pulse: end the run immediately.
- start_in  in  1  raw asynchronous start event.
- stop_in  in  1  raw asynchronous stop event.
- start_out  out  1  gated start level to the datapath.
- stop_out  out  1  gated stop level to the datapath.
- meas_done  in  1  datapath result-valid strobe.
- meas_time  in  64  datapath result, valid with meas_done.
- fifo_rd_en  in  1  pop the FIFO head.
- fifo_rd_data  out  64  FIFO head; valid while !fifo_empty.
- fifo_empty  out  1  FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  high in every state except IDLE.
- ok_cnt  out  16  measurements stored or dropped on overflow in this run.
- to_cnt  out  16  timed-out measurements in this run.
- timeout_err  out  1  sticky timeout flag.
- overflow_err  out  1  sticky FIFO-overflow flag.

Behaviour:
- Reset values: all outputs 0, fifo_empty=1, state IDLE, FIFO empty.
- Input synchronisation: start_in and stop_in pass through 2-flop synchronisers; a rising edge is detected on the synchronised signal, 3 clk after the input edge.
- States: IDLE, ARM, WAIT_STOP, WAIT_DONE, STORE, GAP.
- IDLE:
  - On cfg_go: latch cfg_count; clear ok_cnt, to_cnt, timeout_err, overflow_err; go to ARM.
  - cfg_go is ignored when not in IDLE.
- ARM:
  - On a start edge: assert start_out for PULSE_LEN cycles, starting the cycle after detection; go to WAIT_STOP.
  - No timeout in ARM.
- WAIT_STOP:
  - On a stop edge: assert stop_out for PULSE_LEN cycles; go to WAIT_DONE.
  - Start edges are ignored.
- WAIT_DONE: on meas_done, capture meas_time and go to STORE.
- Timeout:
  - One 32-bit counter clears on entry to WAIT_STOP and on entry to WAIT_DONE.
  - If it reaches TIMEOUT_CYC in either state: to_cnt+1, set timeout_err, go to GAP; nothing is written to the FIFO.
- STORE (1 cycle):
  - Write the captured value if the FIFO is not full, or if it is full and fifo_rd_en is high that same cycle.
  - Otherwise drop the value and set overflow_err.
  - ok_cnt+1 in both cases; then go to GAP.
- GAP:
  - Hold HOLDOFF cycles.
  - Then go to IDLE if cfg_count≠0 and ok_cnt+to_cnt==cfg_count; otherwise go to ARM.
- meas_done outside WAIT_DONE is ignored.
- cfg_abort in any non-IDLE state:
  - Next state is IDLE; start_out/stop_out drop next cycle.
  - FIFO contents, counters and flags are kept.
  - Abort has priority over every other event in the same cycle.
- FIFO:
  - First-word-fall-through.
  - fifo_rd_en while empty is ignored.
  - Simultaneous read and write leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters wrap at 16 bits; a continuous run (cfg_count=0) never self-terminates.
- Asynchronous reset mid-run returns everything to reset values immediately.

Test Plan:
- Single measurement:
  - Stimulus: cfg_count=1, go; start_in edge; 100 cycles later stop_in edge; meas_done with meas_time=0x1234 after 50 cycles.
  - Response: start_out then stop_out high 4 cycles each; fifo_rd_data=0x1234; fifo_level=1; ok_cnt=1; busy low after 16 GAP cycles.
- Three-measurement run:
  - Stimulus: cfg_count=3; results 10, 20, 30.
  - Response: FIFO pops 10, 20, 30 in order; ok_cnt=3; to_cnt=0; returns to IDLE; a 4th start edge produces no start_out.
- Timeout:
  - Stimulus: TIMEOUT_CYC=200; cfg_count=2; first measurement gets a start edge but no stop edge; second completes with 0x55.
  - Response: timeout_err=1; to_cnt=1; ok_cnt=1; FIFO holds only 0x55.
- Overflow:
  - Stimulus: FIFO_DEPTH=8; cfg_count=10; no reads; results 1..10.
  - Response: FIFO holds 1..8; overflow_err=1; ok_cnt=10.
  - Repeat with fifo_rd_en asserted in the 9th STORE cycle: 9 is stored and fifo_level stays 8.
- Abort:
  - Stimulus: cfg_abort in WAIT_DONE, with meas_done in the same cycle.
  - Response: next state IDLE; nothing written; stop_out low the next cycle; previous FIFO data intact.
- Continuous and ignored inputs:
  - Stimulus: cfg_count=0, run 5 measurements then abort; also pulse cfg_go mid-run.
  - Response: ok_cnt=5; the mid-run cfg_go has no effect (counters not cleared).
